// File: rtl/game_score_ctrl.sv
// rtl/game_score_ctrl.sv - Flappy Bird button conditioning, game state machine and scoring
module game_score_btn #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic clr,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // A level is accepted only after it differs from the current one for a full count.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign press = level & ~level_d;
endmodule

module game_score_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SCORE_MAX       = 2047
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        flap_btn,
    input  logic        pause_btn,
    input  logic        pipe_passed,
    input  logic        collision,
    output logic        flap_pulse,
    output logic        paused,
    output logic        gamestate,
    output logic [1:0]  state,
    output logic [10:0] score,
    output logic [10:0] high_score
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [10:0] SMAX = 11'(SCORE_MAX);

    state_t      cur;
    state_t      nxt;
    logic [10:0] score_n;
    logic [10:0] high_n;
    logic        flap_n;
    logic        flap_ev;
    logic        pause_ev;

    game_score_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_flap (
        .clk   (clk),
        .clr   (clr),
        .btn   (flap_btn),
        .press (flap_ev)
    );

    game_score_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
        .clk   (clk),
        .clr   (clr),
        .btn   (pause_btn),
        .press (pause_ev)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cur        <= IDLE;
            score      <= '0;
            high_score <= '0;
            flap_pulse <= 1'b0;
        end else begin
            cur        <= nxt;
            score      <= score_n;
            high_score <= high_n;
            flap_pulse <= flap_n;
        end
    end

    // Collision outranks everything in PLAY: no score, no flap that cycle.
    always_comb begin
        nxt     = cur;
        score_n = score;
        high_n  = high_score;
        flap_n  = 1'b0;
        case (cur)
            IDLE: begin
                score_n = '0;
                if (flap_ev) begin
                    nxt    = PLAY;
                    flap_n = 1'b1;
                end
            end
            PLAY: begin
                if (collision) begin
                    nxt = OVER;
                    if (score > high_score) high_n = score;
                end else begin
                    if (pause_ev) nxt = PAUSE;
                    if (pipe_passed && (score < SMAX)) score_n = score + 11'd1;
                    flap_n = flap_ev;
                end
            end
            PAUSE: begin
                if (pause_ev) nxt = PLAY;
            end
            OVER: begin
                if (flap_ev) begin
                    nxt     = IDLE;
                    score_n = '0;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    assign state     = cur;
    assign paused    = (cur == PAUSE);
    assign gamestate = (cur != OVER);
endmodule

// File: doc/game_score_ctrl.md
# game_score_ctrl

Gameplay control and scoring block for the Flappy Bird top level. It conditions the raw flap and pause pushbuttons with a synchroniser, a debouncer and a one-shot, runs the game-state machine, and counts the score. It produces the `score` and `gamestate` values that the 7-segment display controller consumes, plus the conditioned `flap_pulse` that drives the VGA/game logic. It is the producer end of the score/game-state interface.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required before a button level is accepted (10 ms at 100 MHz).
- `SCORE_MAX`, default 2047: saturation value of `score`; must be ≤ 2047.

- `clk` in 1: master clock, 100 MHz.
- `clr` in 1: reset, asynchronous, active-high; clears all state.
- `flap_btn` in 1: raw flap pushbutton, asynchronous, active-high.
- `pause_btn` in 1: raw pause pushbutton, asynchronous, active-high.
- `pipe_passed` in 1: one-cycle pulse from game logic, synchronous to `clk`; the bird cleared a pipe.
- `collision` in 1: synchronous to `clk`; the bird hit a pipe or the ground (pulse or level).
- `flap_pulse` out 1: one-cycle flap command to game logic.
- `paused` out 1: high while in PAUSE.
- `gamestate` out 1: 1 = game alive (IDLE/PLAY/PAUSE), 0 = game over; display blinks when 0.
- `state` out 2: IDLE=0, PLAY=1, PAUSE=2, OVER=3.
- `score` out 11: current score, binary.
- `high_score` out 11: best score since `clr`.

## Operation
**Button conditioning (one identical channel per button)**
- Two-flop synchroniser, then a debounce counter sized as clog2(DEBOUNCE_CYCLES+1).
- Counter clears whenever the synchronised level equals the debounced level.
- Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES, the debounced level takes the synchronised level and the counter clears.
- Press event: one-cycle pulse on the debounced 0→1 edge. Releases generate no event.

**State machine (reset state IDLE)**
- IDLE: `score` held at 0. Flap event → PLAY and assert `flap_pulse` that cycle. Pause, `pipe_passed` and `collision` are ignored.
- PLAY:
  - `collision` → OVER.
  - Else pause event → PAUSE.
  - Else `pipe_passed` → `score` increments, saturating at SCORE_MAX.
  - A flap event asserts `flap_pulse`.
  - Priority: collision > pause > pipe_passed. On a collision cycle, a simultaneous `pipe_passed` is not counted and a flap event produces no pulse.
  - `pipe_passed` on the same cycle as a pause event is counted.
- PAUSE: pause event → PLAY. Flap events, `pipe_passed` and `collision` are ignored; `flap_pulse` stays 0. `score` is held.
- OVER: `score` is held. A flap event → IDLE and `score` clears to 0 on that transition; no `flap_pulse` is emitted. Pause is ignored.
- High score: `high_score` ← `score` on the PLAY→OVER transition cycle when `score` > `high_score`. It is cleared only by `clr`.

**Outputs**
- `paused` = (state == PAUSE).
- `gamestate` = (state != OVER).
- All outputs are registered or decoded directly from registered state; no combinational path from inputs to outputs.

## Timing
- Reset values: `state`=IDLE, `score`=0, `high_score`=0, `flap_pulse`=0, `paused`=0, `gamestate`=1; synchronisers, debounced levels and counters all 0.
- A `clr` assertion mid-game returns to IDLE immediately (asynchronous) and loses `high_score`.
- Button latency:
  - Raw rising edge sampled at edge 0 → synchronised level at edge 2.
  - Debounced level high at edge 2+DEBOUNCE_CYCLES.
  - `flap_pulse` and state transition registered at edge 3+DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no event.
- A held button produces exactly one event per press.
- `pipe_passed` and `collision` act on the cycle they are sampled; `score` and `state` update at the next edge.
- Saturation: at SCORE_MAX, further `pipe_passed` pulses leave `score` unchanged; there is no wrap to 0.

## Test plan
Use DEBOUNCE_CYCLES=4, SCORE_MAX=5.
- Reset, then flap held high 20 cycles → exactly one `flap_pulse`, 7 cycles after the first sampling edge; `state` 0→1.
- In PLAY, a 3-cycle flap glitch → no `flap_pulse`; then a clean press → one pulse.
- In PLAY, 7 `pipe_passed` pulses → `score` reads 1,2,3,4,5,5,5.
- `score`=3, then `collision` and `pipe_passed` on the same cycle → `state`=3, `score`=3, `gamestate`=0, `high_score`=3.
- PAUSE: `pipe_passed`, `collision` and flap all ignored (`score` unchanged, `flap_pulse`=0); a pause press → PLAY.
- OVER, flap press → IDLE with `score`=0 and `high_score` retained; then `clr` pulsed mid-PLAY → every output returns to its reset value asynchronously.
